// File: rtl/audio_pkg.sv
// Shared definitions for the codec audio path (DAC serializer and ADC side).
// Holds the default channel width and buffer depth, the frame state encoding
// and the stereo pair type used when a left/right sample pair travels as one word.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 32;
  localparam int unsigned AUDIO_FIFO_DEPTH = 8;

  // Which half of the LRCK frame is being serialised.
  typedef enum logic [1:0] {
    StIdle,
    StLeft,
    StRight
  } frame_state_e;

  // {left, right} with left in the upper half.
  typedef logic [2*AUDIO_DATA_WIDTH-1:0] audio_pair_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample write handshake between the mixing logic and the DAC serializer.
//   left/right_channel_audio_out : sample pair to enqueue (master -> slave)
//   write_audio_out              : enqueue strobe (master -> slave)
//   audio_out_allowed            : FIFO can take a pair this cycle (slave -> master)
//   audio_out_used               : pairs currently buffered (slave -> master)
interface audio_dac_serializer_if
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) ();

  localparam int unsigned UsedW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic                  audio_out_allowed;
  logic [UsedW-1:0]      audio_out_used;

  modport master (
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    input  audio_out_allowed,
    input  audio_out_used
  );

  modport slave (
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    output audio_out_allowed,
    output audio_out_used
  );

endinterface

// File: rtl/audio_out_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : synchronous flush (same effect as reset)
//   push_i/wdata_i: enqueue, ignored when full
//   pop_i/rdata_o : dequeue head, ignored when empty; rdata_o shows the head
//   full_o/empty_o/used_o : status derived from the registered count
// Pop only sees entries present before the current cycle (no write bypass).
module audio_out_fifo
  import audio_pkg::*;
#(
  parameter int unsigned Width = 2 * AUDIO_DATA_WIDTH,
  parameter int unsigned Depth = AUDIO_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   used_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned UsedW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [UsedW-1:0] used_q, used_d;
  logic             push_ok, pop_ok;

  assign full_o  = (used_q == UsedW'(Depth));
  assign empty_o = (used_q == '0);
  assign used_o  = used_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      used_d = used_q + UsedW'(push_ok) - UsedW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Transmit half of the codec audio path. Buffers left/right sample pairs and
// shifts them out MSB-first, left-justified, framed by the codec bit clock and
// DAC LR clock (both asynchronous to CLOCK_50).
//   CLOCK_50, resetn        : system clock, synchronous active-low reset
//   clear_audio_out_memory  : flush FIFO, shifter and underrun flag
//   bus (slave)             : sample write handshake and occupancy
//   AUD_BCLK, AUD_DACLRCK   : codec clocks (LRCK high = left channel)
//   underrun                : sticky, a left frame began with the FIFO empty
//   AUD_DACDAT              : registered serial data to the codec
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         clear_audio_out_memory,
  audio_dac_serializer_if.slave        bus,
  input  logic                         AUD_BCLK,
  input  logic                         AUD_DACLRCK,
  output logic                         underrun,
  output logic                         AUD_DACDAT
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_WIDTH - 1);

  // Two synchroniser stages plus a history stage per codec clock: [0],[1] sync, [2] history.
  logic [2:0] bclk_sync_q, bclk_sync_d;
  logic [2:0] lr_sync_q, lr_sync_d;
  logic       bclk_fall, lr_rise, lr_fall;

  frame_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [BitW-1:0]         bitcnt_q, bitcnt_d;
  logic                    dacdat_q, dacdat_d;
  logic                    underrun_q, underrun_d;

  logic [2*DATA_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop;
  logic                    allowed;

  assign bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
  assign lr_sync_d   = {lr_sync_q[1:0], AUD_DACLRCK};

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lr_rise   = ~lr_sync_q[2] & lr_sync_q[1];
  assign lr_fall   = lr_sync_q[2] & ~lr_sync_q[1];

  assign allowed               = resetn & ~clear_audio_out_memory & ~fifo_full;
  assign push                  = bus.write_audio_out & allowed;
  assign bus.audio_out_allowed = allowed;

  audio_out_fifo #(
    .Width (2 * DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (resetn),
    .clear_i (clear_audio_out_memory),
    .push_i  (push),
    .wdata_i ({bus.left_channel_audio_out, bus.right_channel_audio_out}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .used_o  (bus.audio_out_used)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    bitcnt_d   = bitcnt_q;
    dacdat_d   = dacdat_q;
    underrun_d = underrun_q;
    pop        = 1'b0;

    if (clear_audio_out_memory) begin
      state_d    = StIdle;
      shift_d    = '0;
      hold_d     = '0;
      bitcnt_d   = '0;
      dacdat_d   = 1'b0;
      underrun_d = 1'b0;
    end else if (lr_rise) begin
      // Frame load takes precedence over a coincident bit-clock shift.
      state_d  = StLeft;
      bitcnt_d = BitMax;
      if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        hold_d  = fifo_rdata[DATA_WIDTH-1:0];
      end else begin
        shift_d    = '0;
        hold_d     = '0;
        underrun_d = 1'b1;
      end
      dacdat_d = shift_d[DATA_WIDTH-1];
    end else if (lr_fall && state_q == StLeft) begin
      state_d  = StRight;
      shift_d  = hold_q;
      bitcnt_d = BitMax;
      dacdat_d = hold_q[DATA_WIDTH-1];
    end else if (bclk_fall && state_q != StIdle) begin
      if (bitcnt_q != '0) begin
        shift_d  = shift_q << 1;
        dacdat_d = shift_q[DATA_WIDTH-2];
        bitcnt_d = bitcnt_q - BitW'(1);
      end else begin
        // Word exhausted: pad the rest of the slot with zeros.
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
    end
  end

  assign underrun   = underrun_q;
  assign AUD_DACDAT = dacdat_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: a model FIFO predicts which pair each frame
// transmits; expected serial words are queued at frame launch and a monitor
// compares them against the bits captured on each rising bit clock.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic CLOCK_50;
  logic resetn;
  logic clear_audio_out_memory;
  logic AUD_BCLK;
  logic AUD_DACLRCK;
  logic underrun;
  logic AUD_DACDAT;

  audio_dac_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  audio_dac_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .resetn                 (resetn),
    .clear_audio_out_memory (clear_audio_out_memory),
    .bus                    (bus),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_DACLRCK            (AUD_DACLRCK),
    .underrun               (underrun),
    .AUD_DACDAT             (AUD_DACDAT)
  );

  int checks = 0;
  int errors = 0;

  audio_pair_t model_q[$];
  logic [63:0] exp_q[$];
  logic        underrun_exp = 1'b0;
  logic [63:0] cap_word;
  logic [63:0] last_cap;
  int          word_idx = 0;
  event        word_ev;

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial word as captured over n bit clocks: the word followed by zero padding.
  function automatic logic [63:0] framed(input logic [31:0] w, input int n);
    logic [63:0] x;
    x = {32'h0, w};
    return x << (n - 32);
  endfunction

  // Monitor: each completed half-frame capture is checked against the scoreboard.
  initial begin
    logic [63:0] exp;
    forever begin
      @(word_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL serial_word[%0d]: got %0h, expected no word", word_idx, cap_word);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (cap_word !== exp) begin
          errors++;
          $display("FAIL serial_word[%0d]: got %0h, expected %0h", word_idx, cap_word, exp);
        end
      end
      word_idx++;
    end
  end

  task automatic write_pair(input logic [31:0] l, input logic [31:0] r);
    bus.left_channel_audio_out  = l;
    bus.right_channel_audio_out = r;
    bus.write_audio_out         = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back({l, r});
    @(negedge CLOCK_50);
    bus.write_audio_out = 1'b0;
  endtask

  // One half-frame of n bit clocks; the LR edge coincides with the first BCLK fall.
  task automatic half(input int n, input logic lr, input bit emit);
    logic [63:0] cap;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      AUD_BCLK = 1'b0;
      if (i == 0) AUD_DACLRCK = lr;
      repeat (8) @(negedge CLOCK_50);
      cap = {cap[62:0], AUD_DACDAT};
      AUD_BCLK = 1'b1;
      repeat (8) @(negedge CLOCK_50);
    end
    last_cap = cap;
    if (emit) begin
      cap_word = cap;
      -> word_ev;
    end
  endtask

  // Full stereo frame; optionally writes a pair in the same cycle as the lr_rise pop.
  task automatic frame(input int n, input bit coinc, input logic [31:0] cl,
                       input logic [31:0] cr);
    int          pre;
    bit          acc;
    audio_pair_t p;
    pre = model_q.size();
    if (pre > 0) begin
      p = model_q.pop_front();
    end else begin
      p = '0;
      underrun_exp = 1'b1;
    end
    exp_q.push_back(framed(p[63:32], n));
    exp_q.push_back(framed(p[31:0], n));
    acc = coinc && (pre < DEPTH);
    if (acc) model_q.push_back({cl, cr});
    fork
      begin
        half(n, 1'b1, 1'b1);
        half(n, 1'b0, 1'b1);
      end
      begin
        if (coinc) begin
          // lr_rise is acted on at the third rising edge after the pin change.
          repeat (2) @(negedge CLOCK_50);
          check("used_before_pop", 64'(bus.audio_out_used), 64'(pre));
          bus.left_channel_audio_out  = cl;
          bus.right_channel_audio_out = cr;
          bus.write_audio_out         = 1'b1;
          @(negedge CLOCK_50);
          bus.write_audio_out = 1'b0;
          check("used_after_pop", 64'(bus.audio_out_used),
                64'(pre - int'(pre > 0) + int'(acc)));
        end
      end
    join
    check("frame_used", 64'(bus.audio_out_used), 64'(model_q.size()));
    check("frame_underrun", 64'(underrun), 64'(underrun_exp));
  endtask

  task automatic pulse_clear();
    clear_audio_out_memory = 1'b1;
    #1;
    check("allowed_during_clear", 64'(bus.audio_out_allowed), 64'(0));
    @(negedge CLOCK_50);
    clear_audio_out_memory = 1'b0;
    model_q.delete();
    underrun_exp = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    resetn                      = 1'b0;
    clear_audio_out_memory      = 1'b0;
    AUD_BCLK                    = 1'b1;
    AUD_DACLRCK                 = 1'b0;
    bus.left_channel_audio_out  = 32'h1234_5678;
    bus.right_channel_audio_out = 32'h9ABC_DEF0;
    bus.write_audio_out         = 1'b1;

    // Reset while a write is being attempted.
    repeat (5) @(negedge CLOCK_50);
    check("reset_allowed", 64'(bus.audio_out_allowed), 64'(0));
    check("reset_used", 64'(bus.audio_out_used), 64'(0));
    check("reset_dacdat", 64'(AUD_DACDAT), 64'(0));
    check("reset_underrun", 64'(underrun), 64'(0));
    bus.write_audio_out = 1'b0;
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("allowed_after_reset", 64'(bus.audio_out_allowed), 64'(1));

    // Basic frame.
    write_pair(32'hA500_0001, 32'h8000_0000);
    check("used_one", 64'(bus.audio_out_used), 64'(1));
    frame(32, 1'b0, '0, '0);

    // Slots longer than the word: trailing zero padding.
    write_pair(32'h1234_5678, 32'hDEAD_BEEF);
    frame(36, 1'b0, '0, '0);

    // Underrun: empty FIFO at lr_rise sends zeros and sets the sticky flag.
    frame(32, 1'b0, '0, '0);
    pulse_clear();
    check("underrun_cleared", 64'(underrun), 64'(0));

    // Fill: eight accepted, ninth dropped.
    for (int i = 1; i <= 9; i++) begin
      w = 32'h0101_0101 * i;
      write_pair(w, ~w);
      if (i >= 8) begin
        check("full_used", 64'(bus.audio_out_used), 64'(8));
        check("full_allowed", 64'(bus.audio_out_allowed), 64'(0));
      end
    end

    // Push while full coincident with pop is dropped; push at 7 with pop keeps 7.
    frame(32, 1'b1, 32'hCAFE_0001, 32'hCAFE_0002);
    frame(32, 1'b1, 32'hBEEF_0003, 32'hBEEF_0004);
    repeat (7) frame(32, 1'b0, '0, '0);

    // Mid-frame clear after 10 left bits.
    write_pair(32'hFFFF_FFFF, 32'h0F0F_0F0F);
    half(10, 1'b1, 1'b0);
    check("dacdat_before_clear", 64'(AUD_DACDAT), 64'(1));
    clear_audio_out_memory = 1'b1;
    @(negedge CLOCK_50);
    clear_audio_out_memory = 1'b0;
    model_q.delete();
    check("dacdat_after_clear", 64'(AUD_DACDAT), 64'(0));
    check("used_after_clear", 64'(bus.audio_out_used), 64'(0));
    // An lr_fall while idle must not start a right-channel word.
    half(32, 1'b0, 1'b0);
    check("idle_after_clear", last_cap, 64'(0));
    write_pair(32'hC3C3_C3C3, 32'h5A5A_5A5A);
    frame(32, 1'b0, '0, '0);

    repeat (4) @(negedge CLOCK_50);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
